// File: rtl/conv_layer_ctrl_gen.sv
// Control generator for one convolution layer task.
// Walks an IMG_W x IMG_H feature map once per input channel and per output
// group, issuing window/accumulate/pool strobes and a line-buffer clear
// between passes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a layer task (IDLE/DONE only)
//   valid_in          upstream pixel valid
//   ready             pixel accepted when valid_in && ready (high in RUN)
//   rst_n_conv        active-low line-buffer clear (registered)
//   valid_in_conv     conv window complete for the accepted pixel (registered)
//   valid_in_accu     partial sum valid for the channel accumulator (registered)
//   accu_last         valid_in_accu on the last input channel (registered)
//   valid_in_maxpool  final conv result valid for pooling (registered)
//   task_over         one-cycle pulse on completion of the layer task
module conv_layer_ctrl_gen #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter int unsigned K       = 3,
    parameter int unsigned IN_CH   = 1,
    parameter int unsigned OUT_GRP = 1,
    parameter int unsigned POOL_EN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic valid_in,
    output logic ready,
    output logic rst_n_conv,
    output logic valid_in_conv,
    output logic valid_in_accu,
    output logic accu_last,
    output logic valid_in_maxpool,
    output logic task_over
);

    localparam int unsigned COL_W = (IMG_W   > 1) ? $clog2(IMG_W)   : 1;
    localparam int unsigned ROW_W = (IMG_H   > 1) ? $clog2(IMG_H)   : 1;
    localparam int unsigned CH_W  = (IN_CH   > 1) ? $clog2(IN_CH)   : 1;
    localparam int unsigned GRP_W = (OUT_GRP > 1) ? $clog2(OUT_GRP) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CH_W-1:0]  ch;
    logic [GRP_W-1:0] grp;
    logic             last_pass;

    logic accept;
    logic col_end;
    logic row_end;
    logic ch_end;
    logic grp_end;
    logic pass_end;
    logic window;
    logic done_entry;

    // Datapath decode shared by the FSM, counters and strobes.
    assign accept     = (state == RUN) && valid_in;
    assign col_end    = (col == COL_W'(IMG_W - 1));
    assign row_end    = (row == ROW_W'(IMG_H - 1));
    assign ch_end     = (ch  == CH_W'(IN_CH - 1));
    assign grp_end    = (grp == GRP_W'(OUT_GRP - 1));
    assign pass_end   = accept && col_end && row_end;
    assign window     = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
    assign done_entry = (state == FLUSH) && last_pass;

    // Pixel handshake is a pure function of state so upstream sees it same-cycle.
    assign ready = (state == RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (pass_end) next_state = FLUSH;
            FLUSH:   next_state = last_pass ? DONE : RUN;
            DONE:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Pixel / channel / group position; last_pass is latched at the end of the
    // final pass so FLUSH knows whether to resume or finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            grp       <= '0;
            last_pass <= 1'b0;
        end else if (done_entry) begin
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            grp       <= '0;
            last_pass <= 1'b0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row       <= '0;
                    last_pass <= ch_end && grp_end;
                    if (ch_end) begin
                        ch  <= '0;
                        grp <= grp_end ? '0 : grp + GRP_W'(1);
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Registered strobes, one cycle after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_n_conv       <= 1'b0;
            valid_in_conv    <= 1'b0;
            valid_in_accu    <= 1'b0;
            accu_last        <= 1'b0;
            valid_in_maxpool <= 1'b0;
            task_over        <= 1'b0;
        end else begin
            // Clear line buffers while in FLUSH and on the cycle after a start from IDLE.
            rst_n_conv       <= !((next_state == FLUSH) || ((state == IDLE) && start));
            valid_in_conv    <= window;
            valid_in_accu    <= window;
            accu_last        <= window && ch_end;
            valid_in_maxpool <= (POOL_EN != 0) && window && ch_end;
            task_over        <= done_entry;
        end
    end

endmodule
